// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the serial command front-end: opcode width, the
// ALU opcode map, the default sync byte and the receiver/frame state sets.
package uart_cmd_rx_pkg;

  localparam int OPC_W = 3;

  // ALU opcode map shared with the downstream ALU.
  localparam logic [OPC_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [OPC_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [OPC_W-1:0] ALU_AND  = 3'd2;
  localparam logic [OPC_W-1:0] ALU_OR   = 3'd3;
  localparam logic [OPC_W-1:0] ALU_XOR  = 3'd4;
  localparam logic [OPC_W-1:0] ALU_SHL  = 3'd5;
  localparam logic [OPC_W-1:0] ALU_SHR  = 3'd6;
  localparam logic [OPC_W-1:0] ALU_PASS = 3'd7;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Byte receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Frame assembler states; FRM_CHK is only reachable with the checksum byte.
  typedef enum logic [2:0] {
    FRM_HUNT,
    FRM_OPC,
    FRM_OPA,
    FRM_OPB,
    FRM_CHK
  } frame_state_t;

  // Checksum carried in the optional fifth byte.
  function automatic logic [7:0] frame_checksum(input logic [7:0] opc_byte,
                                                input logic [7:0] op_a,
                                                input logic [7:0] op_b);
    return opc_byte ^ op_a ^ op_b;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, modulo-CLKS_PER_BIT bit timer and a
// four-state byte FSM. Emits a one-cycle byte_valid (good stop bit) or
// byte_ferr (stop bit low); data holds the last assembled byte.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          valid_n;
  logic          ferr_n;

  // Synchronize rx and keep one extra stage for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte FSM state, bit timer, shift register and registered strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      byte_valid <= valid_n;
      byte_ferr  <= ferr_n;
    end
  end

  // Next-state logic: sample mid-bit, LSB first; stop bit decides valid/ferr.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          valid_n = rx_sync;
          ferr_n  = !rx_sync;
          state_n = RX_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign data = shreg;

endmodule

// File: rtl/uart_cmd_rx.sv
// Serial command front-end: assembles sync/opcode/A/B frames from the byte
// receiver and presents registered a, b, opcode with a cmd_valid pulse and a
// sticky cmd_ena level. Malformed or stalled frames give a frame_err pulse.
// Optional feature: define UART_CMD_RX_CHECKSUM_EN for a fifth checksum byte
// (opcode byte ^ A ^ B) that must match before the frame commits.
//
// Handshake: none. cmd_valid is a single-cycle strobe; a, b and opcode are
// valid in that same cycle and stay unchanged until the next cmd_valid.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = 16,
  parameter int         FRAME_TIMEOUT = 4096,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic [7:0]       a,
  output logic [7:0]       b,
  output logic [OPC_W-1:0] opcode,
  output logic             cmd_valid,
  output logic             cmd_ena,
  output logic             frame_err
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(FRAME_TIMEOUT);

  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ferr;
  frame_state_t     fstate;
  frame_state_t     fstate_n;
  logic [OPC_W-1:0] sh_opc;
  logic [OPC_W-1:0] sh_opc_n;
  logic [7:0]       sh_a;
  logic [7:0]       sh_a_n;
  logic [7:0]       commit_b;
  logic [TW-1:0]    tmo_cnt;
  logic             timeout;
  logic             commit;
  logic             reject;
`ifdef UART_CMD_RX_CHECKSUM_EN
  logic [7:0]       sh_b;
  logic [7:0]       sh_b_n;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data      (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr)
  );

  // A received byte on the same cycle as expiry keeps the frame alive.
  assign timeout = (fstate != FRM_HUNT) && (tmo_cnt == TMO_LIMIT) && !byte_valid;

  // Frame state and shadow operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fstate <= FRM_HUNT;
      sh_opc <= '0;
      sh_a   <= '0;
`ifdef UART_CMD_RX_CHECKSUM_EN
      sh_b   <= '0;
`endif
    end else begin
      fstate <= fstate_n;
      sh_opc <= sh_opc_n;
      sh_a   <= sh_a_n;
`ifdef UART_CMD_RX_CHECKSUM_EN
      sh_b   <= sh_b_n;
`endif
    end
  end

  // Inter-byte idle counter: zero in HUNT, cleared by every good byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (fstate_n == FRM_HUNT || byte_valid) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LIMIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Frame assembly: decide advance, commit or reject for each byte event.
  always_comb begin
    fstate_n = fstate;
    sh_opc_n = sh_opc;
    sh_a_n   = sh_a;
`ifdef UART_CMD_RX_CHECKSUM_EN
    sh_b_n   = sh_b;
    commit_b = sh_b;
`else
    commit_b = byte_data;
`endif
    commit   = 1'b0;
    reject   = 1'b0;
    if (fstate == FRM_HUNT) begin
      // Framing errors and foreign bytes are ignored while hunting.
      if (byte_valid && byte_data == SYNC_BYTE) fstate_n = FRM_OPC;
    end else if (byte_valid) begin
      case (fstate)
        FRM_OPC: begin
          if (byte_data[7:OPC_W] != '0) begin
            reject = 1'b1;
          end else begin
            sh_opc_n = byte_data[OPC_W-1:0];
            fstate_n = FRM_OPA;
          end
        end
        FRM_OPA: begin
          sh_a_n   = byte_data;
          fstate_n = FRM_OPB;
        end
        FRM_OPB: begin
`ifdef UART_CMD_RX_CHECKSUM_EN
          sh_b_n   = byte_data;
          fstate_n = FRM_CHK;
`else
          commit   = 1'b1;
`endif
        end
`ifdef UART_CMD_RX_CHECKSUM_EN
        FRM_CHK: begin
          if (byte_data == frame_checksum({{(8-OPC_W){1'b0}}, sh_opc}, sh_a, sh_b))
            commit = 1'b1;
          else
            reject = 1'b1;
        end
`endif
        default: fstate_n = FRM_HUNT;
      endcase
    end else if (byte_ferr || timeout) begin
      reject = 1'b1;
    end
    if (commit || reject) fstate_n = FRM_HUNT;
  end

  // Output registers: only a commit updates the command fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      cmd_valid <= 1'b0;
      cmd_ena   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= commit;
      frame_err <= reject;
      if (commit) begin
        a       <= sh_a;
        b       <= commit_b;
        opcode  <= sh_opc;
        cmd_ena <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial byte driver, frame-level reference model
// feeding an expected queue, and a monitor that checks every output pulse.
module tb_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int TMO = 4096;
`ifdef UART_CMD_RX_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam int W = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       cmd_valid;
  logic       cmd_ena;
  logic       frame_err;

  uart_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .FRAME_TIMEOUT(TMO),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .cmd_valid(cmd_valid),
    .cmd_ena  (cmd_ena),
    .frame_err(frame_err)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Expected events: {is_err, opcode[2:0], a[7:0], b[7:0]}
  logic [W-1:0] exp_q[$];

  // Reference model state: bytes collected for the current frame.
  int         m_pos;
  logic [7:0] m_fb[5];
  logic [7:0] m_a, m_b;
  logic [2:0] m_opc;
  logic       m_ena;

  // Monitor's record of the last committed command.
  logic [7:0] mon_a, mon_b;
  logic [2:0] mon_opc;
  logic       mon_ena;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reject();
    exp_q.push_back({1'b1, 19'd0});
    m_pos = 0;
  endtask

  // Frame rules applied to one received byte (ferr = stop bit was low).
  task automatic model_byte(input logic [7:0] v, input bit ferr);
    bit ok;
    if (m_pos == 0) begin
      if (!ferr && v == 8'hA5) m_pos = 1;
      return;
    end
    if (ferr) begin
      model_reject();
      return;
    end
    m_fb[m_pos] = v;
    m_pos++;
    if (m_pos == 2 && v > 8'd7) begin
      model_reject();
      return;
    end
    if (m_pos == NBYTES) begin
      ok = 1'b1;
`ifdef UART_CMD_RX_CHECKSUM_EN
      ok = (m_fb[4] == (m_fb[1] ^ m_fb[2] ^ m_fb[3]));
`endif
      if (ok) begin
        m_opc = m_fb[1][2:0];
        m_a   = m_fb[2];
        m_b   = m_fb[3];
        m_ena = 1'b1;
        exp_q.push_back({1'b0, m_opc, m_a, m_b});
        m_pos = 0;
      end else begin
        model_reject();
      end
    end
  endtask

  task automatic model_timeout();
    if (m_pos != 0) model_reject();
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_a = 8'h00; m_b = 8'h00; m_opc = 3'd0; m_ena = 1'b0;
    mon_a = 8'h00; mon_b = 8'h00; mon_opc = 3'd0; mon_ena = 1'b0;
    exp_q.delete();
  endtask

  // Driver tasks (called at a falling clock edge)
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit bad_stop, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) @(negedge clock);
    end
    model_byte(v, bad_stop);
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clock);
    idle(gap + (bad_stop ? 2 * CPB : 0));
  endtask

  task automatic send_frame(input logic [7:0] opc_byte, input logic [7:0] va,
                            input logic [7:0] vb, input bit csum_bad, input int bad_idx);
    logic [7:0] fb[5];
    fb[0] = 8'hA5;
    fb[1] = opc_byte;
    fb[2] = va;
    fb[3] = vb;
    fb[4] = opc_byte ^ va ^ vb ^ (csum_bad ? 8'h01 : 8'h00);
    for (int i = 0; i < NBYTES; i++)
      send_byte(fb[i], i == bad_idx, $urandom_range(0, 12));
  endtask

  task automatic do_reset(input int n);
    rx = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_opcode"}, opcode, m_opc);
    check({tag, "_a"}, a, m_a);
    check({tag, "_b"}, b, m_b);
    check({tag, "_ena"}, cmd_ena, m_ena);
  endtask

  function automatic logic [7:0] rand_not_sync();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'hA5) v = 8'h5A;
    return v;
  endfunction

  // Scoreboard monitor: every pulse pops one expected event.
  initial begin : monitor
    logic [W-1:0] e;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (cmd_valid || frame_err) begin
          check("pulse_excl", {31'd0, cmd_valid & frame_err}, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, cmd_valid, frame_err}, 0);
          end else begin
            e = exp_q.pop_front();
            if (e[19]) begin
              check("err_pulse", {30'd0, cmd_valid, frame_err}, 1);
            end else begin
              check("commit_pulse", {30'd0, cmd_valid, frame_err}, 2);
              check("commit_opcode", opcode, e[18:16]);
              check("commit_a", a, e[15:8]);
              check("commit_b", b, e[7:0]);
              check("commit_ena", cmd_ena, 1);
              mon_opc = e[18:16];
              mon_a   = e[15:8];
              mon_b   = e[7:0];
              mon_ena = 1'b1;
            end
          end
        end else if (cyc % 64 == 0) begin
          check("stable_opcode", opcode, mon_opc);
          check("stable_a", a, mon_a);
          check("stable_b", b, mon_b);
          check("stable_ena", cmd_ena, mon_ena);
        end
      end
    end
  end

  // Main stimulus
  initial begin : stim
    int kind;
    int n_tmo;
    logic [7:0] ob;
    n_tmo = 0;
    model_reset();
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_a", a, 0);
    check("reset_b", b, 0);
    check("reset_opcode", opcode, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_cmd_ena", cmd_ena, 0);
    check("reset_frame_err", frame_err, 0);
    idle(2 * CPB);

    // Basic frame
    send_frame(8'h02, 8'h12, 8'h34, 1'b0, -1);
    drain("basic");
    check_outputs("basic");

    // Leading noise byte in HUNT
    send_byte(8'h00, 1'b0, 5);
    send_frame(8'h07, 8'hFF, 8'h01, 1'b0, -1);
    drain("noise");
    check_outputs("noise");

    // Bad opcode high bits, then recovery
    send_frame(8'h0A, 8'h12, 8'h34, 1'b0, -1);
    drain("badopc");
    check_outputs("badopc");
    send_frame(8'h03, 8'h55, 8'hAA, 1'b0, -1);
    drain("recover");
    check_outputs("recover");

    // Inter-byte timeout
    send_byte(8'hA5, 1'b0, 3);
    send_byte(8'h02, 1'b0, 0);
    model_timeout();
    idle(5000);
    send_byte(8'h12, 1'b0, 3);
    send_byte(8'h34, 1'b0, 3);
    drain("timeout");
    check_outputs("timeout");

    // Low stop bit on the third byte
    send_frame(8'h05, 8'h77, 8'h66, 1'b0, 2);
    drain("stopbit");
    check_outputs("stopbit");

    // Short glitch on idle line
    rx = 1'b0;
    repeat (6) @(negedge clock);
    idle(4 * CPB);
    drain("glitch");
    check_outputs("glitch");

`ifdef UART_CMD_RX_CHECKSUM_EN
    send_frame(8'h02, 8'h12, 8'h34, 1'b0, -1);
    drain("csum_ok");
    check_outputs("csum_ok");
    send_frame(8'h06, 8'h12, 8'h34, 1'b1, -1);
    drain("csum_bad");
    check_outputs("csum_bad");
`endif

    // Randomized frames
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      ob = 8'($urandom_range(0, 7));
      case (kind)
        5: begin
          ob = {5'($urandom_range(1, 31)), 3'($urandom_range(0, 7))};
          if (ob == 8'hA5) ob = 8'h08;
          send_frame(ob, rand_not_sync(), rand_not_sync(), 1'b0, -1);
        end
        6: begin
          send_byte(rand_not_sync(), 1'b0, $urandom_range(0, 12));
          send_frame(ob, rand_not_sync(), rand_not_sync(), 1'b0, -1);
        end
        7: send_frame(ob, rand_not_sync(), rand_not_sync(), 1'b0,
                      $urandom_range(0, NBYTES - 1));
        8: send_frame(ob, rand_not_sync(), rand_not_sync(), 1'b1, -1);
        9: begin
          if (n_tmo < 2) begin
            n_tmo++;
            send_byte(8'hA5, 1'b0, 2);
            send_byte(ob, 1'b0, 0);
            model_timeout();
            idle(TMO + 200);
          end else begin
            send_frame(ob, rand_not_sync(), rand_not_sync(), 1'b0, -1);
          end
        end
        default: send_frame(ob, rand_not_sync(), rand_not_sync(), 1'b0, -1);
      endcase
      drain("rand");
      check_outputs("rand");
    end

    // Reset in the middle of a byte of a partial frame
    send_byte(8'hA5, 1'b0, 2);
    send_byte(8'h04, 1'b0, 2);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clock);
    do_reset(3);
    idle(3 * CPB);
    check("midreset_a", a, 0);
    check("midreset_b", b, 0);
    check("midreset_opcode", opcode, 0);
    check("midreset_cmd_valid", cmd_valid, 0);
    check("midreset_cmd_ena", cmd_ena, 0);
    check("midreset_frame_err", frame_err, 0);
    send_frame(8'h01, 8'h3C, 8'hC3, 1'b0, -1);
    drain("postreset");
    check_outputs("postreset");

    idle(20);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
